// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Program loader that feeds the instruction-memory write port. It takes a
//   byte stream, assembles 32-bit big-endian words and writes them to
//   consecutive word addresses. The processor is held in reset (cpuHold) until
//   a complete image with a matching checksum has been loaded.
//
//   Frame: SYNC_BYTE, CNT_HI, CNT_LO, 4*N data bytes (MSB first), CSUM
//   CSUM is the XOR of the data bytes only.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous reset, active-low
//   byteValid  in   byteData valid this cycle
//   byteData   in   stream byte
//   byteReady  out  loader accepts a byte (transfer = byteValid & byteReady)
//   reload     in   pulse: leave DONE/ERR and restart the load
//   memWrEn    out  one-cycle write strobe per word
//   memAddr    out  write word address
//   memWrData  out  write data
//   cpuHold    out  1 = keep processor in reset
//   loadDone   out  image loaded and checksum OK
//   loadErr    out  checksum mismatch or oversize image
//
//   state  | meaning
//   IDLE   | hunting for SYNC_BYTE, other bytes dropped
//   CNT_HI | expecting word count high byte
//   CNT_LO | expecting word count low byte, size check
//   DATA   | assembling words, one write per 4 bytes
//   CSUM   | expecting checksum byte
//   DONE   | image good, processor released
//   ERR    | image bad, processor held
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int              ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [7:0]      SYNC_BYTE = 8'hA5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              byteValid,
  input  logic [7:0]        byteData,
  output logic              byteReady,
  input  logic              reload,
  output logic              memWrEn,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWrData,
  output logic              cpuHold,
  output logic              loadDone,
  output logic              loadErr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  state_t              state_q, state_d;
  logic [7:0]          cnt_hi_q, cnt_hi_d;
  logic [15:0]         rem_q, rem_d;       // words still to receive
  logic [1:0]          idx_q, idx_d;       // byte position within word
  logic [31:0]         word_q, word_d;
  logic [7:0]          csum_q, csum_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wr_data_q, wr_data_d;

  logic                xfer;
  logic [15:0]         count;
  logic [31:0]         word_next;

  assign byteReady = (state_q != S_DONE) && (state_q != S_ERR);
  assign xfer      = byteValid & byteReady;
  assign count     = {cnt_hi_q, byteData};
  assign word_next = {word_q[23:0], byteData};

  assign memWrEn   = wr_en_q;
  assign memAddr   = addr_q;
  assign memWrData = wr_data_q;
  assign cpuHold   = (state_q != S_DONE);
  assign loadDone  = (state_q == S_DONE);
  assign loadErr   = (state_q == S_ERR);

  always_comb begin
    state_d   = state_q;
    cnt_hi_d  = cnt_hi_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    word_d    = word_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;

    // Address advances at the end of the strobe cycle so it is stable while
    // memWrEn is high.
    if (wr_en_q) begin
      addr_d = addr_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (xfer && (byteData == SYNC_BYTE)) begin
          state_d = S_CNT_HI;
          csum_d  = 8'h00;
          idx_d   = 2'd0;
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          cnt_hi_d = byteData;
          state_d  = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (xfer) begin
          rem_d = count;
          if ({16'd0, count} > CAPACITY) begin
            state_d = S_ERR;
          end else if (count == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = word_next;
          csum_d = csum_q ^ byteData;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = word_next;
            rem_d     = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = (byteData == csum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_d = S_IDLE;
          addr_d  = BASE_ADDR;
          csum_d  = 8'h00;
          idx_d   = 2'd0;
          rem_d   = 16'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_hi_q  <= 8'h00;
      rem_q     <= 16'd0;
      idx_q     <= 2'd0;
      word_q    <= 32'd0;
      csum_q    <= 8'h00;
      wr_en_q   <= 1'b0;
      addr_q    <= BASE_ADDR;
      wr_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_hi_q  <= cnt_hi_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;

  // main instance, default parameters
  logic        bv_m = 1'b0, rl_m = 1'b0;
  logic [7:0]  bd_m = 8'h00;
  logic        rdy_m, we_m, hold_m, done_m, err_m;
  logic [9:0]  addr_m;
  logic [31:0] wd_m;

  // small instance: 16-word memory, base near the top to exercise wrap
  logic        bv_s = 1'b0, rl_s = 1'b0;
  logic [7:0]  bd_s = 8'h00;
  logic        rdy_s, we_s, hold_s, done_s, err_s;
  logic [3:0]  addr_s;
  logic [31:0] wd_s;

  int errors = 0;
  int checks = 0;
  int wcount_m = 0;
  int wcount_s = 0;
  int ea_m = 0;
  int ea_s = 14;
  int qa_m[$], qa_s[$];
  logic [31:0] qd_m[$], qd_s[$];
  logic [31:0] wa [4];
  int wbefore;

  always #5 CLK = ~CLK;

  instr_mem_loader dut (
    .CLK(CLK), .RST(RST), .byteValid(bv_m), .byteData(bd_m), .byteReady(rdy_m),
    .reload(rl_m), .memWrEn(we_m), .memAddr(addr_m), .memWrData(wd_m),
    .cpuHold(hold_m), .loadDone(done_m), .loadErr(err_m)
  );

  instr_mem_loader #(.ADDR_W(4), .BASE_ADDR(4'hE), .SYNC_BYTE(8'hA5)) dut_s (
    .CLK(CLK), .RST(RST), .byteValid(bv_s), .byteData(bd_s), .byteReady(rdy_s),
    .reload(rl_s), .memWrEn(we_s), .memAddr(addr_s), .memWrData(wd_s),
    .cpuHold(hold_s), .loadDone(done_s), .loadErr(err_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every strobe must match the oldest pending expectation
  always @(negedge CLK) begin
    if (we_m === 1'b1) begin
      wcount_m++;
      checks++;
      assert (qa_m.size() != 0) else begin
        errors++;
        $error("FAIL wr_unexpected_m observed addr=%h data=%h expected none", addr_m, wd_m);
      end
      if (qa_m.size() != 0) begin
        chk("wr_addr_m", 32'(addr_m), 32'(qa_m.pop_front()));
        chk("wr_data_m", wd_m, qd_m.pop_front());
      end
    end
    if (we_s === 1'b1) begin
      wcount_s++;
      checks++;
      assert (qa_s.size() != 0) else begin
        errors++;
        $error("FAIL wr_unexpected_s observed addr=%h data=%h expected none", addr_s, wd_s);
      end
      if (qa_s.size() != 0) begin
        chk("wr_addr_s", 32'(addr_s), 32'(qa_s.pop_front()));
        chk("wr_data_s", wd_s, qd_s.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic send(input bit s, input logic [7:0] b);
    if (s) begin bv_s = 1'b1; bd_s = b; end
    else   begin bv_m = 1'b1; bd_m = b; end
    @(posedge CLK); #1;
    bv_m = 1'b0;
    bv_s = 1'b0;
  endtask

  task automatic pulse_reload(input bit s);
    if (s) rl_s = 1'b1; else rl_m = 1'b1;
    @(posedge CLK); #1;
    rl_m = 1'b0;
    rl_s = 1'b0;
    if (s) ea_s = 14; else ea_m = 0;
  endtask

  task automatic frame(input bit s, input int n, input logic [31:0] w [4],
                       input bit bad, input int gap, input bit rl_mid);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] nn;
    cs = 8'h00;
    nn = 16'(n);
    send(s, 8'hA5);
    send(s, nn[15:8]);
    send(s, nn[7:0]);
    for (int i = 0; i < n; i++) begin
      if (s) begin
        qa_s.push_back(ea_s); qd_s.push_back(w[i]); ea_s = (ea_s + 1) % 16;
      end else begin
        qa_m.push_back(ea_m); qd_m.push_back(w[i]); ea_m = (ea_m + 1) % 1024;
      end
      if (rl_mid) begin
        if (s) rl_s = 1'b1; else rl_m = 1'b1;
      end
      for (int j = 0; j < 4; j++) begin
        b  = w[i][31-8*j -: 8];
        cs = cs ^ b;
        send(s, b);
        repeat (gap) begin @(posedge CLK); #1; end
      end
    end
    rl_m = 1'b0;
    rl_s = 1'b0;
    send(s, bad ? (cs ^ 8'h01) : cs);
  endtask

  task automatic chk_reset_m(input string tag);
    chk({tag, "_rdy"},  32'(rdy_m),  32'd1);
    chk({tag, "_we"},   32'(we_m),   32'd0);
    chk({tag, "_addr"}, 32'(addr_m), 32'd0);
    chk({tag, "_wd"},   wd_m,        32'd0);
    chk({tag, "_hold"}, 32'(hold_m), 32'd1);
    chk({tag, "_done"}, 32'(done_m), 32'd0);
    chk({tag, "_err"},  32'(err_m),  32'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_m("rst");
    chk("rst_addr_s", 32'(addr_s), 32'hE);
    RST = 1'b1;
    @(posedge CLK); #1;

    // two-word image, correct checksum
    wa = '{32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0};
    frame(1'b0, 2, wa, 1'b0, 0, 1'b0);
    chk("t1_done", 32'(done_m), 32'd1);
    chk("t1_hold", 32'(hold_m), 32'd0);
    chk("t1_err",  32'(err_m),  32'd0);
    chk("t1_rdy",  32'(rdy_m),  32'd0);
    chk("t1_addr", 32'(addr_m), 32'd2);

    // bytes offered in DONE are ignored
    bv_m = 1'b1; bd_m = 8'hA5;
    @(posedge CLK); #1;
    bv_m = 1'b0;
    chk("done_ignore", 32'(done_m), 32'd1);

    pulse_reload(1'b0);
    chk("rl_hold", 32'(hold_m), 32'd1);
    chk("rl_done", 32'(done_m), 32'd0);
    chk("rl_addr", 32'(addr_m), 32'd0);

    // same image, corrupted checksum
    frame(1'b0, 2, wa, 1'b1, 0, 1'b0);
    chk("t2_err",  32'(err_m),  32'd1);
    chk("t2_done", 32'(done_m), 32'd0);
    chk("t2_hold", 32'(hold_m), 32'd1);
    chk("t2_rdy",  32'(rdy_m),  32'd0);
    pulse_reload(1'b0);
    chk("t2_rl_err", 32'(err_m), 32'd0);

    // leading junk, empty image
    wbefore = wcount_m;
    send(1'b0, 8'h00);
    send(1'b0, 8'hFF);
    frame(1'b0, 0, wa, 1'b0, 0, 1'b0);
    chk("t3_done", 32'(done_m), 32'd1);
    chk("t3_nowr", 32'(wcount_m), 32'(wbefore));
    pulse_reload(1'b0);

    // reset in the middle of the second word
    send(1'b0, 8'hA5); send(1'b0, 8'h00); send(1'b0, 8'h02);
    qa_m.push_back(0); qd_m.push_back(32'h11223344);
    send(1'b0, 8'h11); send(1'b0, 8'h22); send(1'b0, 8'h33); send(1'b0, 8'h44);
    send(1'b0, 8'h55); send(1'b0, 8'h66);
    RST = 1'b0;
    #1;
    chk_reset_m("t5");
    @(posedge CLK); #1;
    RST = 1'b1;
    ea_m = 0;
    ea_s = 14;
    @(posedge CLK); #1;

    // full image with gaps and reload held during data (must be ignored)
    wa = '{32'hCAFEF00D, 32'h00000001, 32'h80000000, 32'h0};
    frame(1'b0, 3, wa, 1'b0, 2, 1'b1);
    chk("t5_done", 32'(done_m), 32'd1);
    chk("t5_hold", 32'(hold_m), 32'd0);
    chk("t5_addr", 32'(addr_m), 32'd3);

    // reload then one-word image
    pulse_reload(1'b0);
    chk("t6_hold_pre", 32'(hold_m), 32'd1);
    wa = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    frame(1'b0, 1, wa, 1'b0, 0, 1'b0);
    chk("t6_done", 32'(done_m), 32'd1);
    chk("t6_hold", 32'(hold_m), 32'd0);

    // small memory: 17 words is oversize
    wbefore = wcount_s;
    send(1'b1, 8'hA5); send(1'b1, 8'h00); send(1'b1, 8'h11);
    chk("t4_err",  32'(err_s),  32'd1);
    chk("t4_rdy",  32'(rdy_s),  32'd0);
    chk("t4_hold", 32'(hold_s), 32'd1);
    chk("t4_nowr", 32'(wcount_s), 32'(wbefore));
    pulse_reload(1'b1);

    // exactly 16 words is accepted into DATA
    send(1'b1, 8'hA5); send(1'b1, 8'h00); send(1'b1, 8'h10);
    chk("cap_err", 32'(err_s), 32'd0);
    chk("cap_rdy", 32'(rdy_s), 32'd1);
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    ea_s = 14;
    ea_m = 0;
    @(posedge CLK); #1;

    // address wrap: base 14 -> 14, 15, 0
    wa = '{32'hA0A0A0A0, 32'h0B0B0B0B, 32'h13579BDF, 32'h0};
    frame(1'b1, 3, wa, 1'b0, 1, 1'b0);
    chk("wrap_done", 32'(done_s), 32'd1);
    chk("wrap_addr", 32'(addr_s), 32'd1);

    repeat (3) @(posedge CLK);
    #1;
    chk("pending_m", 32'(qa_m.size()), 32'd0);
    chk("pending_s", 32'(qa_s.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
